vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 191 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scan-out: timing counter, RAM window fetch, 8-entry palette, night dimming and
// double-buffer swap at the start of vertical blanking.
module vga_scanout #(
  parameter int unsigned COOR_WIDTH       = 12,
  parameter int unsigned HSIZE            = 1280,
  parameter int unsigned HFP              = 1344,
  parameter int unsigned HSP              = 1480,
  parameter int unsigned HMAX             = 1680,
  parameter int unsigned VSIZE            = 800,
  parameter int unsigned VFP              = 801,
  parameter int unsigned VSP              = 804,
  parameter int unsigned VMAX             = 828,
  parameter bit          HSPP             = 1'b1,
  parameter bit          VSPP             = 1'b1,
  parameter int unsigned FRAME_LEFT       = 0,
  parameter int unsigned FRAME_RIGHT      = 1280,
  parameter int unsigned FRAME_TOP        = 250,
  parameter int unsigned FRAME_BOTTOM     = 550,
  parameter int unsigned RAM_WIDTH        = 20,
  parameter int unsigned RAM_LATENCY      = 2,
  parameter int unsigned NIGHT_RATE_WIDTH = 8
) (
  input  logic                        clk_vga,
  input  logic                        rst_n,
  input  logic [NIGHT_RATE_WIDTH-1:0] night_rate,
  input  logic                        pal_we,
  input  logic [2:0]                  pal_idx,
  input  logic [23:0]                 pal_rgb,
  output logic                        rd_en,
  output logic [RAM_WIDTH-1:0]        rd_addr,
  input  logic [2:0]                  rd_palette,
  output logic                        read_part,
  output logic                        write_part,
  output logic                        frame_done,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        data_enable,
  output logic [7:0]                  output_red,
  output logic [7:0]                  output_green,
  output logic [7:0]                  output_blue
);

  localparam int unsigned W       = NIGHT_RATE_WIDTH;
  localparam int unsigned WinW    = FRAME_RIGHT - FRAME_LEFT;
  localparam int unsigned WinH    = FRAME_BOTTOM - FRAME_TOP;
  localparam int unsigned RamSize = WinW * WinH;

  typedef logic [COOR_WIDTH-1:0] coor_t;

  localparam coor_t XLast  = coor_t'(HMAX - 1);
  localparam coor_t YLast  = coor_t'(VMAX - 1);
  localparam coor_t XWinLo = coor_t'(FRAME_LEFT);
  localparam coor_t YWinLo = coor_t'(FRAME_TOP);
  localparam coor_t WinWC  = coor_t'(WinW);
  localparam coor_t WinHC  = coor_t'(WinH);

  if (FRAME_BOTTOM > VSIZE || FRAME_RIGHT > HSIZE || RAM_LATENCY < 1) begin : g_bad_params
    $error("vga_scanout: window must lie inside the active area and RAM_LATENCY >= 1");
  end

  coor_t x_q, y_q;
  coor_t off_x, off_y;
  logic  win_now;
  logic  read_part_q;
  logic [W-1:0] rate_q;

  coor_t x_pipe_q [RAM_LATENCY];
  coor_t y_pipe_q [RAM_LATENCY];
  logic [RAM_LATENCY-1:0] vld_pipe_q;

  logic [23:0] pal_q [8];

  // Offsets wrap to huge values left/above the window, so one unsigned compare suffices.
  assign off_x   = x_q - XWinLo;
  assign off_y   = y_q - YWinLo;
  assign win_now = (off_x < WinWC) && (off_y < WinHC);

  assign rd_en      = rst_n & win_now;
  assign frame_done = rst_n & (x_q == '0) & (y_q == coor_t'(VSIZE));
  assign read_part  = read_part_q;
  assign write_part = ~read_part_q;

  always_comb begin
    rd_addr = '0;
    if (rd_en) begin
      rd_addr = (read_part_q ? RAM_WIDTH'(RamSize) : '0) + RAM_WIDTH'(off_x)
              + RAM_WIDTH'(off_y) * RAM_WIDTH'(WinW);
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (x_q == XLast) begin
      x_q <= '0;
      y_q <= (y_q == YLast) ? '0 : y_q + 1'b1;
    end else begin
      x_q <= x_q + 1'b1;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      read_part_q <= 1'b0;
      rate_q      <= '0;
    end else if (frame_done) begin
      read_part_q <= ~read_part_q;
      rate_q      <= night_rate;
    end
  end

  // Valid bits keep the reset contents of the delay line from reaching the outputs.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        x_pipe_q[i] <= '0;
        y_pipe_q[i] <= '0;
      end
      vld_pipe_q <= '0;
    end else begin
      x_pipe_q[0]   <= x_q;
      y_pipe_q[0]   <= y_q;
      vld_pipe_q[0] <= 1'b1;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        x_pipe_q[i]   <= x_pipe_q[i-1];
        y_pipe_q[i]   <= y_pipe_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        pal_q[i] <= {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
      end
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  function automatic logic [7:0] dim(input logic [7:0] c, input logic [W-1:0] r);
    logic [W:0]   f;
    logic [W+7:0] p;
    f = {1'b1, {W{1'b0}}} - {1'b0, r};
    p = {{W{1'b0}}, c} * {7'd0, f};
    if (&r) return 8'd0;
    return 8'(p >> W);
  endfunction

  coor_t tap_x, tap_y;
  logic  tap_v, tap_active, tap_win, hs_d, vs_d;
  logic [23:0] base_rgb, rgb_d;

  assign tap_x = x_pipe_q[RAM_LATENCY-1];
  assign tap_y = y_pipe_q[RAM_LATENCY-1];
  assign tap_v = vld_pipe_q[RAM_LATENCY-1];

  always_comb begin
    tap_active = tap_v && (tap_x < coor_t'(HSIZE)) && (tap_y < coor_t'(VSIZE));
    tap_win    = ((tap_x - XWinLo) < WinWC) && ((tap_y - YWinLo) < WinHC);
    hs_d       = (tap_v && tap_x >= coor_t'(HFP) && tap_x < coor_t'(HSP)) ? HSPP : ~HSPP;
    vs_d       = (tap_v && tap_y >= coor_t'(VFP) && tap_y < coor_t'(VSP)) ? VSPP : ~VSPP;
    base_rgb   = tap_win ? pal_q[rd_palette] : 24'hFFFFFF;
    rgb_d      = '0;
    if (tap_active) begin
      rgb_d = {dim(base_rgb[23:16], rate_q), dim(base_rgb[15:8], rate_q),
               dim(base_rgb[7:0], rate_q)};
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= ~HSPP;
      vsync        <= ~VSPP;
      data_enable  <= 1'b0;
      output_red   <= '0;
      output_green <= '0;
      output_blue  <= '0;
    end else begin
      hsync        <= hs_d;
      vsync        <= vs_d;
      data_enable  <= tap_active;
      output_red   <= rgb_d[23:16];
      output_green <= rgb_d[15:8];
      output_blue  <= rgb_d[7:0];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a tiny 12x7 raster with a 4x2 RAM window; expected values
// come from arithmetic on the cycle index since reset release.
module tb_vga_scanout;

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic [7:0]  night_rate;
  logic        pal_we;
  logic [2:0]  pal_idx;
  logic [23:0] pal_rgb;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [2:0]  rd_palette;
  logic        read_part, write_part, frame_done, hsync, vsync, data_enable;
  logic [7:0]  output_red, output_green, output_blue;

  always #5 clk_vga = ~clk_vga;

  vga_scanout #(
    .COOR_WIDTH(12), .HSIZE(8), .HFP(9), .HSP(10), .HMAX(12),
    .VSIZE(4), .VFP(5), .VSP(6), .VMAX(7), .HSPP(1'b1), .VSPP(1'b1),
    .FRAME_LEFT(2), .FRAME_RIGHT(6), .FRAME_TOP(1), .FRAME_BOTTOM(3),
    .RAM_WIDTH(20), .RAM_LATENCY(2), .NIGHT_RATE_WIDTH(8)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .night_rate(night_rate), .pal_we(pal_we),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_palette(rd_palette), .read_part(read_part), .write_part(write_part),
    .frame_done(frame_done), .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
    .output_red(output_red), .output_green(output_green), .output_blue(output_blue)
  );

  // Two-cycle RAM: contents are only changed while the DUT is held in reset.
  logic [2:0] ram_mem [16];
  logic [2:0] ram_s1, ram_s2;
  always @(posedge clk_vga) begin
    ram_s1 <= ram_mem[rd_addr[3:0]];
    ram_s2 <= ram_s1;
  end
  assign rd_palette = ram_s2;

  int tests = 0;
  int fails = 0;
  int n;
  int last_fd;
  int rate_m;
  logic [23:0] pal_m [8];
  logic        exp_hs, exp_vs, exp_de;
  logic [23:0] exp_rgb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): got %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  function automatic int rp_of(input int c);
    return ((c + 35) / 84) % 2;
  endfunction

  function automatic bit in_win(input int x, input int y);
    return x >= 2 && x < 6 && y >= 1 && y < 3;
  endfunction

  function automatic int addr_of(input int c);
    int x = c % 12;
    int y = (c / 12) % 7;
    return rp_of(c) * 8 + (x - 2) + (y - 1) * 4;
  endfunction

  function automatic logic [7:0] dimc(input int c, input int r);
    if (r == 255) return 8'd0;
    return 8'((c * (256 - r)) >> 8);
  endfunction

  task automatic model_reset();
    n       = 0;
    last_fd = -1;
    rate_m  = 0;
    for (int i = 0; i < 8; i++) pal_m[i] = {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
    exp_hs  = 1'b0;
    exp_vs  = 1'b0;
    exp_de  = 1'b0;
    exp_rgb = '0;
  endtask

  task automatic chk_reset();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_read_part", read_part, 0);
    chk("rst_write_part", write_part, 1);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_de", data_enable, 0);
    chk("rst_rgb", {output_red, output_green, output_blue}, 0);
  endtask

  task automatic check_cycle();
    int x = n % 12;
    int y = (n / 12) % 7;
    bit w = in_win(x, y);
    chk("rd_en", rd_en, w);
    chk("rd_addr", rd_addr, w ? addr_of(n) : 0);
    chk("frame_done", frame_done, (x == 0 && y == 4));
    chk("read_part", read_part, rp_of(n));
    chk("write_part", write_part, 1 - rp_of(n));
    chk("hsync", hsync, exp_hs);
    chk("vsync", vsync, exp_vs);
    chk("data_enable", data_enable, exp_de);
    chk("rgb", {output_red, output_green, output_blue}, exp_rgb);
    if (frame_done) begin
      if (last_fd >= 0) chk("frame_period", n - last_fd, 84);
      last_fd = n;
    end
  endtask

  // Predict the registers loaded at the next edge, then apply that edge's state changes.
  task automatic advance();
    int p = n - 2;
    if (p >= 0) begin
      int px = p % 12;
      int py = (p / 12) % 7;
      logic [23:0] base;
      base    = in_win(px, py) ? pal_m[ram_mem[addr_of(p)]] : 24'hFFFFFF;
      exp_hs  = (px == 9);
      exp_vs  = (py == 5);
      exp_de  = (px < 8 && py < 4);
      exp_rgb = exp_de ? {dimc(base[23:16], rate_m), dimc(base[15:8], rate_m),
                          dimc(base[7:0], rate_m)} : 24'h0;
    end
    if (pal_we) pal_m[pal_idx] = pal_rgb;
    if (n % 12 == 0 && (n / 12) % 7 == 4) rate_m = night_rate;
    n++;
  endtask

  task automatic cycle();
    check_cycle();
    advance();
    @(negedge clk_vga);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    night_rate = 8'd0;
    pal_we     = 1'b0;
    pal_idx    = 3'd0;
    pal_rgb    = 24'h0;
    for (int i = 0; i < 16; i++) ram_mem[i] = 3'd4;
    model_reset();
    repeat (3) @(negedge clk_vga);
    #1;
    chk_reset();

    // Phase A: index 4 everywhere; rate changes mid-frame; palette rewrite while streaming.
    rst_n = 1'b1;
    for (int i = 0; i < 449; i++) begin
      if (i == 60)  night_rate = 8'd128;
      if (i == 150) night_rate = 8'd255;
      if (i == 220) night_rate = 8'd0;
      if (i == 436) begin
        pal_we  = 1'b1;
        pal_idx = 3'd4;
        pal_rgb = 24'h123456;
      end
      cycle();
      pal_we = 1'b0;
    end

    // Mid-frame reset while an in-window pixel is on the outputs and read_part is 1.
    check_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    for (int i = 0; i < 16; i++) ram_mem[i] = 3'($urandom_range(0, 7));
    model_reset();
    repeat (2) begin
      @(negedge clk_vga);
      #1;
      chk_reset();
    end

    // Phase B: random RAM contents, palette writes and night_rate changes.
    rst_n = 1'b1;
    for (int i = 0; i < 420; i++) begin
      pal_we  = ($urandom_range(0, 7) == 0);
      pal_idx = 3'($urandom_range(0, 7));
      pal_rgb = 24'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       night_rate = 8'd0;
          1:       night_rate = 8'd128;
          2:       night_rate = 8'd255;
          default: night_rate = 8'($urandom);
        endcase
      end
      cycle();
    end
    pal_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
